sdram_avm_bridge: RTL and testbench

- Avalon-MM slave front-end that sits directly downstream of the system-console JTAG master (32-bit address/data, 4-bit byteenable, waitrequest, pipelined readdatavalid).
- Queues accepted reads and writes into a command FIFO and presents them to the SDRAM controller core as a valid/ready command stream.
- Returns read responses to the master through readdatavalid, in order.
- Decouples master timing from controller busy periods such as refresh, activate and precharge.

---
 rtl/sdram_bridge_pkg.sv | 20 ++
 rtl/sdram_cmd_fifo.sv | 55 +++++
 rtl/sdram_avm_bridge.sv | 134 +++++++++++++
 tb/tb_sdram_avm_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bridge_pkg.sv
// Shared widths, the command record carried through the bridge FIFO and the
// byte-to-word address helper for the Avalon-MM to SDRAM command bridge.
package sdram_bridge_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_BE_W   = PKG_DATA_W / 8;

  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-3:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
    logic [PKG_BE_W-1:0]   be;
  } cmd_t;

  function automatic logic [PKG_ADDR_W-3:0] word_addr(input logic [PKG_ADDR_W-1:0] byte_addr);
    return (PKG_ADDR_W-2)'(byte_addr >> 2);
  endfunction

endpackage

// File: rtl/sdram_cmd_fifo.sv
// First-word-fall-through command FIFO: dout_o always shows the head entry,
// empty_o/count_o describe occupancy. DEPTH must be a power of two.
module sdram_cmd_fifo
  import sdram_bridge_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  cmd_t          din_i,
  input  logic          pop_i,
  output cmd_t          dout_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & (count_q != CW'(DEPTH));
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage needs no reset: only pointer/count state decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sdram_avm_bridge.sv
// Avalon-MM slave to SDRAM controller command/response bridge with a registered
// waitrequest. Optional access counters are enabled with `define BRIDGE_STATS_EN.
module sdram_avm_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_W      = PKG_ADDR_W,
  parameter int DATA_W      = PKG_DATA_W,
  parameter int BE_W        = PKG_BE_W,
  parameter int CMD_DEPTH   = 4,
  parameter int MAX_RD_PEND = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [BE_W-1:0]   avs_byteenable,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-3:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic [BE_W-1:0]   cmd_be,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
`ifdef BRIDGE_STATS_EN
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_rd_cnt,
`endif
  output logic              err_o
);

  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int RW = 6;
  localparam logic [CW-1:0] FIFO_HI = CW'(CMD_DEPTH - 1);
  localparam logic [RW-1:0] RD_HI   = RW'(MAX_RD_PEND - 1);

  // Handshakes: an Avalon access is taken on any cycle with read|write high and
  // waitrequest low; a command transfers on cmd_valid & cmd_ready and cmd_* hold
  // while cmd_valid & !cmd_ready; rsp_valid is a one-cycle strobe with no ready.
  logic              wait_q, wait_d;
  logic              rdv_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q, err_d;
  logic [RW-1:0]     pend_q, pend_d;
  logic [RW-1:0]     rdq_q, rdq_d;
  logic [CW-1:0]     fifo_cnt, fifo_cnt_nxt;
  logic              fifo_empty;
  cmd_t              push_cmd, head;
  logic              accept, push, pop, pop_rd, rsp_ok;

  always_comb begin
    accept         = (avs_read | avs_write) & ~wait_q;
    // Write wins over a simultaneous read; an all-lanes-off write is a no-op.
    push           = accept & (~avs_write | (avs_byteenable != '0));
    push_cmd.write = avs_write;
    push_cmd.addr  = word_addr(avs_address);
    push_cmd.wdata = avs_writedata;
    push_cmd.be    = avs_byteenable;
    pop            = ~fifo_empty & cmd_ready;
    pop_rd         = pop & ~head.write;
    rsp_ok         = rsp_valid & (pend_q != '0);
    pend_d         = pend_q + RW'(pop_rd) - RW'(rsp_ok);
    rdq_d          = rdq_q + RW'(push & ~avs_write) - RW'(pop_rd);
    fifo_cnt_nxt   = fifo_cnt + CW'(push) - CW'(pop);
    // Raised one entry early so an access landing as it rises still fits.
    wait_d         = (fifo_cnt_nxt >= FIFO_HI) | ((pend_d + rdq_d) >= RD_HI);
    err_d          = err_q
                   | (accept & avs_read & avs_write)
                   | (push & (avs_address[1:0] != 2'b00))
                   | (rsp_valid & ~rsp_ok);
  end

  sdram_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (push),
    .din_i   (push_cmd),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wait_q  <= 1'b1;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= '0;
      rdq_q   <= '0;
    end else begin
      wait_q <= wait_d;
      rdv_q  <= rsp_ok;
      if (rsp_ok) rdata_q <= rsp_data;
      err_q  <= err_d;
      pend_q <= pend_d;
      rdq_q  <= rdq_d;
    end
  end

  assign avs_waitrequest   = wait_q;
  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdata_q;
  assign cmd_valid         = ~fifo_empty;
  assign cmd_write         = head.write;
  assign cmd_addr          = head.addr;
  assign cmd_wdata         = head.wdata;
  assign cmd_be            = head.be;
  assign err_o             = err_q;

`ifdef BRIDGE_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (push & avs_write & (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (push & ~avs_write & (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign stat_wr_cnt = wr_cnt_q;
  assign stat_rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_avm_bridge.sv
// Bench for sdram_avm_bridge: Avalon driver, SDRAM controller model with its own
// memory, and a negedge monitor that scores every output against a reference.
module tb_sdram_avm_bridge;

  localparam int CMD_DEPTH   = 4;
  localparam int MAX_RD_PEND = 4;
  localparam int EW          = 67;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [29:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        err_o;
`ifdef BRIDGE_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

  always #5 clk_clk = ~clk_clk;

  sdram_avm_bridge #(.CMD_DEPTH(CMD_DEPTH), .MAX_RD_PEND(MAX_RD_PEND)) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .cmd_be            (cmd_be),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
`ifdef BRIDGE_STATS_EN
    .stat_wr_cnt       (stat_wr_cnt),
    .stat_rd_cnt       (stat_rd_cnt),
`endif
    .err_o             (err_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [EW-1:0] cmd_exp_q[$];
  logic [31:0]   rd_exp_q[$];
  logic [31:0]   ref_mem[16];
  logic [31:0]   ctrl_mem[16];
  int          ready_mode = 1;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          spur_req = 1'b0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- controller model ----------------
  initial begin
    int          cyc, last_due, due;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic        p, pw;
    logic [29:0] pa;
    logic [31:0] pd;
    logic [3:0]  pb;
    cyc = 0; last_due = 0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    for (int i = 0; i < 16; i++) ctrl_mem[i] = '0;
    forever begin
      @(negedge clk_clk);
      p = reset_reset_n && cmd_valid && cmd_ready;
      pw = cmd_write; pa = cmd_addr; pd = cmd_wdata; pb = cmd_be;
      @(posedge clk_clk); #1;
      cyc++;
      rsp_valid = 1'b0;
      if (!reset_reset_n) begin
        due_q.delete(); dat_q.delete(); last_due = 0; cmd_ready = 1'b0;
      end else begin
        if (p) begin
          if (pw) ctrl_mem[pa[3:0]] = merge(ctrl_mem[pa[3:0]], pd, pb);
          else begin
            due = cyc + $urandom_range(lat_min, lat_max) - 1;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
            dat_q.push_back(ctrl_mem[pa[3:0]]);
          end
        end
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
          rsp_valid = 1'b1;
          rsp_data  = dat_q.pop_front();
          void'(due_q.pop_front());
        end else if (spur_req) begin
          rsp_valid = 1'b1;
          rsp_data  = $urandom();
          spur_req  = 1'b0;
        end
        case (ready_mode)
          0:       cmd_ready = 1'b0;
          1:       cmd_ready = 1'b1;
          default: cmd_ready = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int          rd_inflight, popped_unans, exp_wr, exp_rd;
    bit          err_exp, rdv_exp, rst_seen, wait_exp;
    logic [EW-1:0] e, act;
    rd_inflight = 0; popped_unans = 0; exp_wr = 0; exp_rd = 0;
    err_exp = 0; rdv_exp = 0; rst_seen = 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        chk("rst_waitrequest", {66'b0, avs_waitrequest}, 67'd1);
        chk("rst_cmd_valid", {66'b0, cmd_valid}, 67'd0);
        chk("rst_readdatavalid", {66'b0, avs_readdatavalid}, 67'd0);
        chk("rst_readdata", {35'b0, avs_readdata}, 67'd0);
        chk("rst_err", {66'b0, err_o}, 67'd0);
        cmd_exp_q.delete(); rd_exp_q.delete();
        rd_inflight = 0; popped_unans = 0; exp_wr = 0; exp_rd = 0;
        err_exp = 0; rdv_exp = 0; rst_seen = 1;
        ref_mem = ctrl_mem;
      end else begin
        wait_exp = rst_seen || (cmd_exp_q.size() >= CMD_DEPTH - 1) ||
                   (rd_inflight >= MAX_RD_PEND - 1);
        rst_seen = 0;
        chk("waitrequest", {66'b0, avs_waitrequest}, {66'b0, wait_exp});
        chk("cmd_valid", {66'b0, cmd_valid}, {66'b0, cmd_exp_q.size() != 0});
        chk("readdatavalid", {66'b0, avs_readdatavalid}, {66'b0, rdv_exp});
        chk("err_o", {66'b0, err_o}, {66'b0, err_exp});
`ifdef BRIDGE_STATS_EN
        chk("stat_wr_cnt", {51'b0, stat_wr_cnt}, EW'(exp_wr));
        chk("stat_rd_cnt", {51'b0, stat_rd_cnt}, EW'(exp_rd));
`endif
        if (avs_readdatavalid) begin
          if (rd_exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL readdata_extra: got readdatavalid with data %h, expected no response", avs_readdata);
          end else chk("readdata", {35'b0, avs_readdata}, {35'b0, rd_exp_q.pop_front()});
        end
        // events that take effect at the coming rising edge
        rdv_exp = 0;
        if (rsp_valid) begin
          if (popped_unans > 0) begin
            popped_unans--; rd_inflight--; rdv_exp = 1;
          end else err_exp = 1;
        end
        if (cmd_valid && cmd_ready && cmd_exp_q.size() != 0) begin
          e   = cmd_exp_q.pop_front();
          act = {cmd_write, cmd_addr, cmd_wdata, cmd_be};
          if (!e[EW-1]) begin
            e[35:4] = '0; act[35:4] = '0;
            popped_unans++;
          end
          chk("cmd_entry", act, e);
        end
        if ((avs_read || avs_write) && !wait_exp) begin
          if (avs_write) begin
            if (avs_read) err_exp = 1;
            if (avs_byteenable != 4'h0) begin
              cmd_exp_q.push_back({1'b1, avs_address[31:2], avs_writedata, avs_byteenable});
              ref_mem[avs_address[5:2]] = merge(ref_mem[avs_address[5:2]], avs_writedata, avs_byteenable);
              if (avs_address[1:0] != 2'b00) err_exp = 1;
              if (exp_wr < 65535) exp_wr++;
            end
          end else begin
            cmd_exp_q.push_back({1'b0, avs_address[31:2], 32'h0, avs_byteenable});
            rd_exp_q.push_back(ref_mem[avs_address[5:2]]);
            rd_inflight++;
            if (avs_address[1:0] != 2'b00) err_exp = 1;
            if (exp_rd < 65535) exp_rd++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    int t;
    t = 0;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d; avs_byteenable = be;
    @(negedge clk_clk);
    while (avs_waitrequest && t < 500) begin
      t++;
      @(negedge clk_clk);
    end
    if (avs_waitrequest) begin
      n_vec++; n_err++;
      $display("FAIL bus_op_timeout: waitrequest still 1 after %0d cycles, expected 0", t);
    end
    @(posedge clk_clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((cmd_exp_q.size() != 0 || rd_exp_q.size() != 0) && t < 1000) begin
      t++;
      @(negedge clk_clk);
    end
    if (cmd_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d cmds and %0d reads outstanding, expected 0",
               cmd_exp_q.size(), rd_exp_q.size());
    end
    repeat (2) @(posedge clk_clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk_clk); #2;
    reset_reset_n = 1'b0;
    #1;
    chk("rst_now_cmd_valid", {66'b0, cmd_valid}, 67'd0);
    chk("rst_now_waitrequest", {66'b0, avs_waitrequest}, 67'd1);
    chk("rst_now_readdatavalid", {66'b0, avs_readdatavalid}, 67'd0);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;
  endtask

  task automatic random_ops(input int n, input bit dirty);
    logic [31:0] a;
    int          op;
    for (int i = 0; i < n; i++) begin
      a = $urandom();
      a[1:0] = dirty ? 2'($urandom_range(0, 3)) : 2'b00;
      op = $urandom_range(0, dirty ? 3 : 1);
      bus_op(op == 0 || op == 2, op != 0, a, $urandom(), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;

    // single write
    ready_mode = 1;
    bus_op(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_idle();

    // backpressure with a stalled controller
    ready_mode = 0;
    repeat (2) @(posedge clk_clk); #1;
    for (int i = 0; i < 3; i++) bus_op(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    fork
      bus_op(1'b0, 1'b1, 32'h10C, 32'hA000_0003, 4'hF);
      begin repeat (6) @(posedge clk_clk); #1 ready_mode = 1; end
    join
    wait_idle();

    // pipelined reads with a fixed 5-cycle latency
    for (int i = 0; i < 4; i++) bus_op(1'b0, 1'b1, 32'(4 * i), 32'(8'h11 * (i + 1)), 4'hF);
    wait_idle();
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 4; i++) bus_op(1'b1, 1'b0, 32'(4 * i), 32'h0, 4'hF);
    wait_idle();

    // clean random traffic
    lat_min = 1; lat_max = 6; ready_mode = 2;
    random_ops(300, 1'b0);
    wait_idle();

    // error cases, each from a fresh reset
    ready_mode = 1;
    bus_op(1'b1, 1'b1, 32'h20, 32'hCAFE_0001, 4'hF);
    wait_idle();
    apply_reset();
    bus_op(1'b0, 1'b1, 32'h3, 32'h1234_5678, 4'hF);
    wait_idle();
    apply_reset();
    spur_req = 1'b1;
    repeat (4) @(posedge clk_clk); #1;
    wait_idle();
    apply_reset();

    // reset with queued writes and an outstanding read
    lat_min = 30; lat_max = 30;
    bus_op(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
    repeat (3) @(posedge clk_clk); #1;
    ready_mode = 0;
    repeat (2) @(posedge clk_clk); #1;
    bus_op(1'b0, 1'b1, 32'h14, 32'h5555_AAAA, 4'hF);
    bus_op(1'b0, 1'b1, 32'h18, 32'hAAAA_5555, 4'h3);
    apply_reset();
    wait_idle();

    // random traffic including protocol errors
    lat_min = 1; lat_max = 6; ready_mode = 2;
    random_ops(150, 1'b1);
    ready_mode = 1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
